// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the VGA timing generator.
package vga_timing_pkg;

  // Default 640x480@60 horizontal timing (pixels)
  localparam int unsigned HD = 640;
  localparam int unsigned HF = 16;
  localparam int unsigned HS = 96;
  localparam int unsigned HB = 48;

  // Default 640x480@60 vertical timing (lines)
  localparam int unsigned VD = 480;
  localparam int unsigned VF = 10;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 33;

  // Pixels per line including blanking.
  function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  // Lines per frame including blanking.
  function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  // Counter width able to hold the larger of H_TOTAL-1 and V_TOTAL-1.
  function automatic int unsigned cnt_width(input int unsigned h_tot, input int unsigned v_tot);
    int unsigned big;
    big = (h_tot > v_tot) ? h_tot : v_tot;
    return (big > 1) ? $clog2(big) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_prescaler.sv
// Pixel-clock prescaler: one-clk advance request every CLK_DIV enabled clocks.
module pixel_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt;

  // Advance on the enabled clk where the phase counter sits at its last value.
  assign tick = enable && (cnt == LAST);

  // Phase counter; holds while disabled so re-enable resumes mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: prescaler, h/v counters and registered sync/blank decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = HD,
  parameter int unsigned H_FRONT   = HF,
  parameter int unsigned H_SYNC    = HS,
  parameter int unsigned H_BACK    = HB,
  parameter int unsigned V_DISPLAY = VD,
  parameter int unsigned V_FRONT   = VF,
  parameter int unsigned V_SYNC    = VS,
  parameter int unsigned V_BACK    = VB,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = cnt_width(h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
                                               v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          pix_tick,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] x_loc,
  output logic [CW-1:0] y_loc,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);

  localparam int unsigned H_TOT = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOT = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          tick;
  logic [CW-1:0] x_nxt_c;
  logic [CW-1:0] y_nxt_c;
  logic          vid_c;
  logic          hs_act_c;
  logic          vs_act_c;
  logic          vblank_c;

  pixel_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick)
  );

  // Next counter position; decode uses it so outputs line up with x_loc/y_loc.
  always_comb begin
    x_nxt_c = x_loc;
    y_nxt_c = y_loc;
    if (tick) begin
      if (x_loc == X_LAST) begin
        x_nxt_c = '0;
        y_nxt_c = (y_loc == Y_LAST) ? '0 : y_loc + CW'(1);
      end else begin
        x_nxt_c = x_loc + CW'(1);
      end
    end
  end

  // Window decode of the next position.
  always_comb begin
    vid_c    = (x_nxt_c < X_VIS) && (y_nxt_c < Y_VIS);
    hs_act_c = (x_nxt_c >= HS_FIRST) && (x_nxt_c <= HS_LAST);
    vs_act_c = (y_nxt_c >= VS_FIRST) && (y_nxt_c <= VS_LAST);
    vblank_c = (y_nxt_c >= Y_VIS);
  end

  // Counters, level outputs and strobes; reset parks at the last pixel so the first advance is (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_loc       <= X_LAST;
      y_loc       <= Y_LAST;
      video_on    <= 1'b0;
      vblank      <= 1'b1;
      h_sync      <= ~HSYNC_POL;
      v_sync      <= ~VSYNC_POL;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x_loc       <= x_nxt_c;
      y_loc       <= y_nxt_c;
      video_on    <= vid_c;
      vblank      <= vblank_c;
      h_sync      <= hs_act_c ? HSYNC_POL : ~HSYNC_POL;
      v_sync      <= vs_act_c ? VSYNC_POL : ~VSYNC_POL;
      pix_tick    <= tick;
      line_start  <= tick && (x_nxt_c == '0);
      frame_start <= tick && (x_nxt_c == '0) && (y_nxt_c == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench for vga_timing_gen against a pixel-index arithmetic model.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic en;

  // Instance A: default 640x480, CLK_DIV=4
  logic       a_pix, a_hs, a_vs, a_vid, a_ls, a_fs, a_vb;
  logic [9:0] a_x, a_y;
  // Instance B: tiny timings, positive polarity, CLK_DIV=1
  logic       b_pix, b_hs, b_vs, b_vid, b_ls, b_fs, b_vb;
  logic [3:0] b_x, b_y;
  // Instance C: tiny line, default frame height, CLK_DIV=2
  logic       c_pix, c_hs, c_vs, c_vid, c_ls, c_fs, c_vb;
  logic [9:0] c_x, c_y;

  longint unsigned ecount;
  bit              counted;
  int              n_checks;
  int              n_errors;
  int              since_rel;
  int              first_tick;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .enable(en), .pix_tick(a_pix), .h_sync(a_hs), .v_sync(a_vs),
    .video_on(a_vid), .x_loc(a_x), .y_loc(a_y), .line_start(a_ls), .frame_start(a_fs),
    .vblank(a_vb)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en), .pix_tick(b_pix), .h_sync(b_hs), .v_sync(b_vs),
    .video_on(b_vid), .x_loc(b_x), .y_loc(b_y), .line_start(b_ls), .frame_start(b_fs),
    .vblank(b_vb)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en), .pix_tick(c_pix), .h_sync(c_hs), .v_sync(c_vs),
    .video_on(c_vid), .x_loc(c_x), .y_loc(c_y), .line_start(c_ls), .frame_start(c_fs),
    .vblank(c_vb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: after reset the raster sits at the last pixel; each CLK_DIV enabled clocks is one
  // pixel advance, so the position is a linear pixel index modulo the frame size.
  task automatic check_inst(input string nm, input int unsigned div,
                            input int unsigned hd, input int unsigned hf,
                            input int unsigned hs, input int unsigned hb,
                            input int unsigned vd, input int unsigned vf,
                            input int unsigned vs, input int unsigned vb,
                            input bit hp, input bit vp,
                            input logic pix, input logic hsy, input logic vsy,
                            input logic vid, input logic ls, input logic fs, input logic vbl,
                            input int unsigned ox, input int unsigned oy);
    longint unsigned ht, vt, tot, n, p, x, y;
    bit adv, exp_hs, exp_vs;
    ht  = longint'(hd + hf + hs + hb);
    vt  = longint'(vd + vf + vs + vb);
    tot = ht * vt;
    n   = ecount / longint'(div);
    p   = (tot - 1 + n) % tot;
    x   = p % ht;
    y   = p / ht;
    adv = counted && ((ecount % longint'(div)) == 0);
    exp_hs = ((x >= hd + hf) && (x < hd + hf + hs)) ? hp : !hp;
    exp_vs = ((y >= vd + vf) && (y < vd + vf + vs)) ? vp : !vp;
    check({nm, ".x"},        32'(ox),  32'(x));
    check({nm, ".y"},        32'(oy),  32'(y));
    check({nm, ".pix_tick"}, 32'(pix), 32'(adv));
    check({nm, ".line"},     32'(ls),  32'(adv && x == 0));
    check({nm, ".frame"},    32'(fs),  32'(adv && x == 0 && y == 0));
    check({nm, ".video_on"}, 32'(vid), 32'(x < hd && y < vd));
    check({nm, ".vblank"},   32'(vbl), 32'(y >= vd));
    check({nm, ".h_sync"},   32'(hsy), 32'(exp_hs));
    check({nm, ".v_sync"},   32'(vsy), 32'(exp_vs));
  endtask

  task automatic check_all();
    check_inst("A", 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
               a_pix, a_hs, a_vs, a_vid, a_ls, a_fs, a_vb, 32'(a_x), 32'(a_y));
    check_inst("B", 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1,
               b_pix, b_hs, b_vs, b_vid, b_ls, b_fs, b_vb, 32'(b_x), 32'(b_y));
    check_inst("C", 2, 8, 2, 2, 2, 480, 10, 2, 33, 1'b0, 1'b0,
               c_pix, c_hs, c_vs, c_vid, c_ls, c_fs, c_vb, 32'(c_x), 32'(c_y));
  endtask

  // One clock: advance the model by what the flops saw at the edge, then check #1 later.
  task automatic step();
    @(posedge clk);
    if (rst_n && en) begin
      ecount++;
      counted = 1'b1;
    end else begin
      counted = 1'b0;
      if (!rst_n) ecount = 0;
    end
    if (rst_n) since_rel++;
    #1;
    check_all();
    if (first_tick < 0 && a_pix === 1'b1) first_tick = since_rel;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    ecount     = 0;
    counted    = 1'b0;
    since_rel  = 0;
    first_tick = -1;
    rst_n      = 1'b0;
    en         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    en    = 1'b1;

    for (int c = 0; c < 30000; c++) begin
      step();
      if (c < 3000) begin
        en = 1'b1;
      end else if (c < 3007) begin
        en = 1'b0;
      end else begin
        en = ($urandom_range(7) != 0);
      end

      // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
      if (c == 15000) begin
        #2;
        rst_n   = 1'b0;
        ecount  = 0;
        counted = 1'b0;
        #1;
        check_all();
      end
      if (c == 15003) begin
        rst_n = 1'b1;
        en    = 1'b1;
      end
    end

    check("first_tick_clk", 32'(first_tick), 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
